fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC stage.
- Takes the current pc/pcplus4 and issues in-order read requests to instruction memory over a valid/ready handshake.
- Buffers up to DEPTH fetched instructions with their pc/pcplus4 and presents them to decode over a valid/ready interface.
- Tells the PC stage when to advance, and discards in-flight fetches on a control-flow flush.

Parameters:
ADDRESS_WIDTH, 32, width of pc, pcplus4, imem_addr
DATA_WIDTH, 32, instruction width
DEPTH, 4, queue entries; power of two, >= 2

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
pc  input  ADDRESS_WIDTH  current PC from PC stage (registered there)
pcplus4  input  ADDRESS_WIDTH  pc + 4 from PC stage
flush  input  1  redirect from execute; discard all queued and in-flight fetches
pc_advance  output  1  PC stage loads next_pc this cycle
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  ADDRESS_WIDTH  fetch address (= pc)
imem_rsp_valid  input  1  response valid; responses strictly in request order
imem_rsp_data  input  DATA_WIDTH  fetched instruction
dec_valid  output  1  instruction available to decode
dec_ready  input  1  decode accepts
dec_instr  output  DATA_WIDTH  head instruction
dec_pc  output  ADDRESS_WIDTH  head pc
dec_pcplus4  output  ADDRESS_WIDTH  head pcplus4
count  output  $clog2(DEPTH)+1  allocated entries
rsp_error  output  1  sticky protocol-error flag

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers, count, drop_cnt and all filled flags go to 0.
  - dec_valid=0, imem_req_valid=0, pc_advance=0, rsp_error=0.
  - Entry payloads do not reset.
- Storage:
  - Circular array of DEPTH entries {pc, pcplus4, instr, filled}.
  - Three pointers: alloc (tail), fill, head.
  - Each pointer has one extra wrap bit, and wraps DEPTH-1 -> 0.
- Request:
  - imem_req_valid = !flush && (count + drop_cnt < DEPTH). Comparison is unsigned and one bit wider.
  - imem_addr = pc, combinational.
  - fire = imem_req_valid && imem_req_ready.
  - pc_advance = fire, combinational.
  - On fire: entry[alloc] <= {pc, pcplus4, filled=0}; alloc++.
  - A pop in the same cycle does not free space for the request (no bypass).
- Response (imem_rsp_valid high):
  - If drop_cnt > 0: drop_cnt--, data discarded.
  - Else if fill != alloc: entry[fill].instr <= data, filled <= 1, fill++.
  - Else (stray response): ignored, rsp_error <= 1 until reset.
- Decode output:
  - dec_valid = entry[head].filled, driven from registered state.
  - dec_instr, dec_pc, dec_pcplus4 come from entry[head].
  - Pop when dec_valid && dec_ready: filled <= 0, head++.
  - Response-to-dec_valid latency is 1 cycle; there is no combinational path from imem_rsp to dec.
- count = alloc - head, where +1 on fire and -1 on pop. Simultaneous fire and pop leaves count unchanged.
- Same-cycle events:
  - Request, response and pop can all occur in the same cycle.
  - When fill and pop target different entries they are independent.
  - Fill cannot target the head entry while that entry is popped, because the head must already be filled to pop.
- Flush, taking priority over all same-cycle queue updates:
  - No request that cycle; pc_advance=0.
  - Pointers, count and filled flags are cleared.
  - drop_cnt <= drop_cnt + (alloc - fill) - (1 if a response arrives this cycle and is consumed by the drop or fill path).
  - Any pop in the flush cycle is cancelled (decode must ignore it).
- Post-flush:
  - Requests may resume the next cycle while drop_cnt > 0.
  - Because responses are in order, dropped responses precede new ones.
- Invariant: count + drop_cnt <= DEPTH; drop_cnt is $clog2(DEPTH)+1 bits.

Test Plan:
1. Streaming: reset, memory always ready, 1-cycle response latency, pc = 0x0, 0x4, 0x8…, dec_ready=1 -> dec_valid first high 2 cycles after first fire; dec_pc 0x0, 0x4, 0x8 in order; dec_pcplus4 0x4, 0x8, 0xC; count steady at 2.
2. Backpressure: dec_ready=0 -> exactly 4 fires, then imem_req_valid=0, pc_advance=0, count=4. Raise dec_ready -> 4 pops in order, then fetching resumes at the held pc.
3. Flush with 2 outstanding: assert flush with alloc - fill = 2, no response that cycle -> count=0, dec_valid=0, drop_cnt=2. The next 2 responses are discarded. New fetch at pc 0x100 returns 0x00500093 -> dec_pc=0x100, dec_instr=0x00500093 as the first entry.
4. Flush coincident with a response and a pop -> response counts toward the drop path, drop_cnt = outstanding - 1, pop cancelled, count=0 next cycle.
5. Stray response: imem_rsp_valid with nothing outstanding and drop_cnt=0 -> rsp_error=1 and stays 1; count, fill and dec_valid unchanged.
6. Mid-operation reset: count=3 with 1 outstanding, drive rst low between clock edges -> dec_valid=0, imem_req_valid=0, count=0 immediately. After release, the first fetch is delivered with dec_pc equal to the pc presented.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage between the PC stage and decode.
//
// Issues in-order fetch requests for the current pc, keeps up to DEPTH
// fetched instructions together with their pc/pcplus4, and hands them to
// decode in program order. On a flush all queued entries are discarded and
// responses still owed by memory are counted so they can be dropped on
// arrival.
//
// Ports:
//   clk            clock, all state on the rising edge
//   rst            asynchronous active-low reset
//   pc, pcplus4    current pc and pc+4 from the PC stage
//   flush          control-flow redirect, discards queued and in-flight fetches
//   pc_advance     PC stage loads next_pc this cycle (request accepted)
//   imem_req_*     fetch request handshake, imem_addr = pc
//   imem_rsp_*     in-order fetch responses (no backpressure)
//   dec_*          head instruction to decode, valid/ready handshake
//   count          allocated entries (alloc - head)
//   rsp_error      sticky flag: a response arrived with nothing owed
module fetch_queue #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] pc,
    input  logic [ADDRESS_WIDTH-1:0] pcplus4,
    input  logic                     flush,
    output logic                     pc_advance,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [DATA_WIDTH-1:0]    dec_instr,
    output logic [ADDRESS_WIDTH-1:0] dec_pc,
    output logic [ADDRESS_WIDTH-1:0] dec_pcplus4,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     rsp_error
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]              r_alloc;
    logic [PW:0]              r_fill;
    logic [PW:0]              r_head;
    logic [PW:0]              r_drop_cnt;
    logic [DEPTH-1:0]         r_filled;
    logic                     r_rsp_error;

    logic [ADDRESS_WIDTH-1:0] r_pc_mem    [DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_pcp4_mem  [DEPTH];
    logic [DATA_WIDTH-1:0]    r_instr_mem [DEPTH];

    logic [PW-1:0]            w_alloc_idx;
    logic [PW-1:0]            w_fill_idx;
    logic [PW-1:0]            w_head_idx;
    logic [PW:0]              w_count;
    logic [PW:0]              w_outstanding;
    logic [PW+1:0]            w_occupancy;
    logic                     w_space;
    logic                     w_req_valid;
    logic                     w_fire;
    logic                     w_dec_valid;
    logic                     w_pop;
    logic                     w_drop_pending;
    logic                     w_rsp_drop;
    logic                     w_rsp_fill;
    logic                     w_rsp_stray;
    logic                     w_rsp_used;
    logic [DEPTH-1:0]         w_filled_next;

    assign w_alloc_idx   = r_alloc[PW-1:0];
    assign w_fill_idx    = r_fill[PW-1:0];
    assign w_head_idx    = r_head[PW-1:0];

    assign w_count       = r_alloc - r_head;
    assign w_outstanding = r_alloc - r_fill;

    // Space accounts for entries owed to a flushed stream as well, so the
    // in-order response stream can never outrun the storage.
    assign w_occupancy   = {1'b0, w_count} + {1'b0, r_drop_cnt};
    assign w_space       = (w_occupancy < DEPTH_W);

    // Gated by rst so the request is withdrawn the moment reset asserts.
    assign w_req_valid   = rst && !flush && w_space;
    assign w_fire        = w_req_valid && imem_req_ready;

    assign w_dec_valid   = r_filled[w_head_idx];
    assign w_pop         = w_dec_valid && dec_ready && !flush;

    assign w_drop_pending = (r_drop_cnt != '0);
    assign w_rsp_drop    = imem_rsp_valid && w_drop_pending;
    assign w_rsp_fill    = imem_rsp_valid && !w_drop_pending && (r_fill != r_alloc);
    assign w_rsp_stray   = imem_rsp_valid && !w_drop_pending && (r_fill == r_alloc);
    assign w_rsp_used    = w_rsp_drop || w_rsp_fill;

    // Fire, pop and fill never target the same entry in one cycle: fire
    // needs a free slot, pop needs a filled head, fill needs an unfilled one.
    always_comb begin
        w_filled_next = r_filled;
        if (w_fire) begin
            w_filled_next[w_alloc_idx] = 1'b0;
        end
        if (w_pop) begin
            w_filled_next[w_head_idx] = 1'b0;
        end
        if (w_rsp_fill) begin
            w_filled_next[w_fill_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alloc     <= '0;
            r_fill      <= '0;
            r_head      <= '0;
            r_drop_cnt  <= '0;
            r_filled    <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            if (w_rsp_stray) begin
                r_rsp_error <= 1'b1;
            end
            if (flush) begin
                r_alloc    <= '0;
                r_fill     <= '0;
                r_head     <= '0;
                r_filled   <= '0;
                // Every request still owed becomes a drop, except one that
                // is being answered (dropped or filled) right now.
                r_drop_cnt <= r_drop_cnt + w_outstanding - (PW+1)'(w_rsp_used);
            end else begin
                if (w_fire) begin
                    r_alloc <= r_alloc + 1'b1;
                end
                if (w_rsp_fill) begin
                    r_fill <= r_fill + 1'b1;
                end
                if (w_pop) begin
                    r_head <= r_head + 1'b1;
                end
                if (w_rsp_drop) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
                r_filled <= w_filled_next;
            end
        end
    end

    // Payload storage carries no reset; the filled flags qualify it.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_pc_mem[w_alloc_idx]   <= pc;
            r_pcp4_mem[w_alloc_idx] <= pcplus4;
        end
        if (w_rsp_fill && !flush) begin
            r_instr_mem[w_fill_idx] <= imem_rsp_data;
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_addr      = pc;
    assign pc_advance     = w_fire;
    assign dec_valid      = w_dec_valid;
    assign dec_instr      = r_instr_mem[w_head_idx];
    assign dec_pc         = r_pc_mem[w_head_idx];
    assign dec_pcplus4    = r_pcp4_mem[w_head_idx];
    assign count          = w_count;
    assign rsp_error      = r_rsp_error;

endmodule
